// File: rtl/audio_pkg.sv
// Shared audio constants (sample width, I2S slot and divider defaults) and the I2S FSM state type.
package audio_pkg;

  localparam int unsigned AudioWidth  = 16;
  localparam int unsigned I2sSlotBits = 32;
  localparam int unsigned I2sClkDiv   = 4;

  typedef enum logic {
    IDLE,
    RUN
  } i2s_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous pin input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S master receiver: drives sck/ws, deserializes the selected channel slot MSB-first and
// presents each completed word on line_out with a one-cycle valid strobe.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH     = AudioWidth,
  parameter int unsigned SLOT_BITS = I2sSlotBits,
  parameter int unsigned CLK_DIV   = I2sClkDiv,
  parameter int unsigned CHANNEL   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sd,
  output logic                    sck,
  output logic                    ws,
  output logic signed [WIDTH-1:0] line_out,
  output logic                    valid
);

  localparam int unsigned DcW = $clog2(CLK_DIV);
  localparam int unsigned BcW = $clog2(2 * SLOT_BITS);

  localparam logic [DcW-1:0] DivLast   = DcW'(CLK_DIV - 1);
  localparam logic [BcW-1:0] BitLast   = BcW'(2 * SLOT_BITS - 1);
  localparam logic [BcW-1:0] SlotBitsC = BcW'(SLOT_BITS);
  localparam logic [BcW-1:0] WidthC    = BcW'(WIDTH);
  localparam logic           ChanC     = (CHANNEL != 0);

  i2s_state_t state_q, state_d;

  logic [DcW-1:0]          div_q, div_d;
  logic [BcW-1:0]          bit_q, bit_d;
  logic                    sck_q, sck_d;
  logic                    ws_q, ws_d;
  logic [WIDTH-1:0]        shift_q, shift_d;
  logic signed [WIDTH-1:0] line_q, line_d;
  logic                    valid_q, valid_d;

  logic           sd_sync;
  logic           slot_hi;
  logic [BcW-1:0] slot_pos;
  logic           rise;
  logic           capture;

  sync_2ff u_sd_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sd),
    .q    (sd_sync)
  );

  assign slot_hi  = (bit_q >= SlotBitsC);
  assign slot_pos = slot_hi ? (bit_q - SlotBitsC) : bit_q;
  // sck toggles as div wraps to 0, so the first high cycle is sck=1 with div=0.
  assign rise     = sck_q && (div_q == '0);
  // Position 0 holds the previous word's trailing bit; positions beyond WIDTH are truncated.
  assign capture  = rise && (slot_hi == ChanC) && (slot_pos != '0) && (slot_pos <= WidthC);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    shift_d = shift_q;
    line_d  = line_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        sck_d   = 1'b0;
        ws_d    = 1'b0;
        shift_d = '0;
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort: park the pins and drop any partial word; line_out keeps its value.
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          ws_d    = 1'b0;
          shift_d = '0;
        end else begin
          if (div_q == DivLast) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (sck_q) begin
              bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
              ws_d  = (bit_d >= SlotBitsC);
            end
          end else begin
            div_d = div_q + 1'b1;
          end

          if (capture) begin
            shift_d = {shift_q[WIDTH-2:0], sd_sync};
            if (slot_pos == WidthC) begin
              line_d  = shift_d;
              valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      shift_q <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  assign sck      = sck_q;
  assign ws       = ws_q;
  assign line_out = line_q;
  assign valid    = valid_q;

endmodule
